answer_reader: RTL and testbench

- Upstream sequencer for the answer ROM.
- On each start request it sweeps the ROM address 0..NUM_WORDS-1 and samples the registered ROM data byte for each address.
- It emits the bytes as a framed valid/ready byte stream, followed by a checksum byte, to the downstream LCB transmitter.
- One full sweep means address 0 and the last address are each visited exactly once, which advances the ROM frame counter by one per frame.

---
 rtl/lcb_pkg.sv | 28 ++
 rtl/answer_reader.sv | 157 +++++++++++++++
 tb/tb_answer_reader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcb_pkg.sv
// Shared definitions for the answer-ROM reader and its LCB stream consumers.
// Holds the sequencer state encoding, default geometry and checksum helpers.
package lcb_pkg;

  localparam int NUM_WORDS = 18;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int RD_LAT    = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PRESENT,
    CHK,
    DONE
  } state_t;

  // Running checksum is a plain wrapping sum; the transmitted byte is its inverse.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] data);
    return acc + data;
  endfunction

  function automatic logic [DATA_W-1:0] csum_final(input logic [DATA_W-1:0] acc);
    return ~acc;
  endfunction

endpackage

// File: rtl/answer_reader.sv
// Sweeps the answer ROM once per start request and streams every byte,
// followed by an inverted-sum checksum byte, over a valid/ready interface.
module answer_reader
  import lcb_pkg::*;
#(
  parameter int P_NUM_WORDS = NUM_WORDS,
  parameter int P_ADDR_W    = ADDR_W,
  parameter int P_DATA_W    = DATA_W,
  parameter int P_RD_LAT    = RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [P_ADDR_W-1:0]   rom_addr,
  input  logic [P_DATA_W-1:0]   rom_data,
  output logic [P_DATA_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sof,
  output logic                  out_eof,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(P_RD_LAT + 1);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(P_RD_LAT - 1);
  localparam logic [P_ADDR_W-1:0] LAST_IDX = P_ADDR_W'(P_NUM_WORDS - 1);

  state_t                state_q, state_d;
  logic [P_ADDR_W-1:0]   addr_q, addr_d;
  logic [P_ADDR_W-1:0]   idx_q, idx_d;
  logic [P_DATA_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [P_DATA_W-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sof_q, sof_d;
  logic                  eof_q, eof_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  handshake;

  assign handshake = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          idx_d   = '0;
          sum_d   = '0;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end

      // The ROM registers its output, so rom_data is only trusted RD_LAT edges after an address change.
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = rom_data;
          sum_d   = csum_add(sum_q, rom_data);
          valid_d = 1'b1;
          sof_d   = (idx_q == '0);
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      PRESENT: begin
        if (handshake) begin
          valid_d = 1'b0;
          sof_d   = 1'b0;
          if (idx_q < LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            addr_d  = idx_q + 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end else begin
            state_d = CHK;
          end
        end
      end

      CHK: begin
        if (!valid_q) begin
          data_d  = csum_final(sum_q);
          valid_d = 1'b1;
          eof_d   = 1'b1;
        end else if (out_ready) begin
          valid_d = 1'b0;
          eof_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      // frame_done is raised on entry so that its single-cycle pulse coincides with this state.
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rom_addr   = addr_q;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_sof    = sof_q;
  assign out_eof    = eof_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_answer_reader.sv
// Scoreboard bench for answer_reader against a model of the answer ROM whose
// address-0 word is a frame counter that advances once per completed sweep.
module tb_answer_reader;
  import lcb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  rom_addr;
  logic [7:0]  rom_data = 8'd0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eof;
  logic        busy;
  logic        frame_done;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          acc_count = 0;
  int          done_count = 0;
  int          next_byte0 = 0;
  int          ready_mode = 0;
  logic [7:0]  rx_sum = 8'd0;
  logic [7:0]  rom_cnt = 8'd0;
  logic [4:0]  rom_prev = 5'd0;

  answer_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Registered answer ROM: word k is 10*k, word 0 is a counter bumped when a sweep wraps from the last address back to 0.
  always @(posedge clk) begin
    if (rom_prev == 5'd17 && rom_addr == 5'd0) begin
      rom_cnt  <= rom_cnt + 8'd1;
      rom_data <= rom_cnt + 8'd1;
    end else if (rom_addr == 5'd0) begin
      rom_data <= rom_cnt;
    end else begin
      rom_data <= 8'(rom_addr * 10);
    end
    rom_prev <= rom_addr;
  end

  // Downstream readiness: 0 = always ready, 1 = random, 2 = stalled.
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected frame built straight from the ROM contents and the checksum rule.
  task automatic pushFrame();
    int   s;
    exp_t e;
    s = next_byte0 % 256;
    e.data = 8'(next_byte0);
    e.sof = 1'b1;
    e.eof = 1'b0;
    exp_q.push_back(e);
    for (int k = 1; k < 18; k++) begin
      s += 10 * k;
      e.data = 8'(10 * k);
      e.sof = 1'b0;
      exp_q.push_back(e);
    end
    e.data = 8'(255 - (s % 256));
    e.sof = 1'b0;
    e.eof = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (!frame_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout after %0d cycles, frame_done 0 required 1", name, budget);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 0);
    checkOutput({tag, "_out_data"}, 32'(out_data), 0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_out_sof"}, 32'(out_sof), 0);
    checkOutput({tag, "_out_eof"}, 32'(out_eof), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 0);
  endtask

  // Monitor: a byte is taken whenever valid and ready are both high ahead of the next edge.
  always @(negedge clk) begin
    if (!rst && frame_done) done_count++;
    if (!rst && out_valid && out_ready) begin
      acc_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_byte actual 0x%0h required none", out_data);
      end else begin
        exp_t e;
        logic [7:0] s;
        e = exp_q.pop_front();
        checkOutput("byte_data", 32'(out_data), 32'(e.data));
        checkOutput("byte_sof", 32'(out_sof), 32'(e.sof));
        checkOutput("byte_eof", 32'(out_eof), 32'(e.eof));
        s = (out_sof ? 8'd0 : rx_sum) + out_data;
        rx_sum <= s;
        if (e.eof) checkOutput("rx_sum", 32'(s), 32'hFF);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int n;
    int dc;
    bit got;

    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1 with a free-flowing sink.
    pushFrame();
    applyStimulus();
    waitDone("frame1_done", 500);
    next_byte0++;
    @(negedge clk);
    checkOutput("frame1_busy_after", 32'(busy), 0);
    checkOutput("frame1_done_pulse", 32'(frame_done), 0);
    checkOutput("frame1_done_count", 32'(done_count), 1);
    checkOutput("frame1_addr_last", 32'(rom_addr), 17);
    checkOutput("frame1_queue", 32'(exp_q.size()), 0);

    // Frame 2 with a 5-cycle stall on byte 3.
    base = acc_count;
    pushFrame();
    applyStimulus();
    n = 0;
    while (acc_count < base + 3 && n < 200) begin @(negedge clk); n++; end
    ready_mode = 2;
    n = 0;
    while (!(out_valid && !out_ready) && n < 50) begin @(negedge clk); n++; end
    checkOutput("stall_reached", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_data", 32'(out_data), 30);
      checkOutput("stall_valid", 32'(out_valid), 1);
      checkOutput("stall_addr", 32'(rom_addr), 3);
      @(negedge clk);
    end
    ready_mode = 0;
    waitDone("frame2_done", 500);
    next_byte0++;
    @(negedge clk);
    checkOutput("frame2_done_count", 32'(done_count), 2);

    // Frame 3: start hammered while busy and during the DONE cycle.
    pushFrame();
    dc = done_count;
    @(negedge clk) start = 1'b1;
    got = 1'b0;
    for (int i = 1; i < 500; i++) begin
      @(negedge clk);
      if (frame_done) begin
        start = 1'b1;
        got = 1'b1;
        break;
      end
      start = (i % 5 == 0);
    end
    @(negedge clk) start = 1'b0;
    checkOutput("repeat_done_seen", 32'(got), 1);
    next_byte0++;
    repeat (40) @(negedge clk);
    checkOutput("repeat_idle_valid", 32'(out_valid), 0);
    checkOutput("repeat_idle_busy", 32'(busy), 0);
    checkOutput("repeat_done_count", 32'(done_count), 32'(dc + 1));
    checkOutput("repeat_queue", 32'(exp_q.size()), 0);

    // Frame 4 aborted by reset while byte 8 is presented, then a clean frame.
    base = acc_count;
    pushFrame();
    applyStimulus();
    n = 0;
    while (acc_count < base + 8 && n < 300) begin @(negedge clk); n++; end
    ready_mode = 2;
    n = 0;
    while (!(out_valid && !out_ready) && n < 50) begin @(negedge clk); n++; end
    checkOutput("abort_byte8", 32'(out_data), 80);
    #2 rst = 1'b1;
    #1 checkResetOutputs("async_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    dc = done_count;
    pushFrame();
    applyStimulus();
    waitDone("after_reset_done", 500);
    next_byte0++;
    @(negedge clk);
    checkOutput("after_reset_done_count", 32'(done_count), 32'(dc + 1));
    checkOutput("after_reset_queue", 32'(exp_q.size()), 0);

    // Twenty frames against a randomly stalling sink.
    ready_mode = 1;
    dc = done_count;
    for (int f = 0; f < 20; f++) begin
      pushFrame();
      applyStimulus();
      waitDone("random_frame_done", 3000);
      next_byte0++;
      @(negedge clk);
    end
    ready_mode = 0;
    repeat (5) @(negedge clk);
    checkOutput("random_done_count", 32'(done_count), 32'(dc + 20));
    checkOutput("final_queue", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
